// File: rtl/reg_file_pkg.sv
// Shared widths and per-port access decode for the dual-port register file.
package reg_file_pkg;

    localparam int RF_DATA_WIDTH = 8;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_REG_COUNT  = 32;

    typedef enum logic [1:0] {
        PORT_IDLE,
        PORT_WRITE,
        PORT_READ,
        PORT_NOACC
    } port_op_e;

    // Case-equality keeps an X on we/oe/cs from ever selecting an access.
    function automatic port_op_e port_decode(input logic cs, input logic we, input logic oe);
        if (cs !== 1'b1) return PORT_IDLE;
        if (we === 1'b1) return PORT_WRITE;
        if (oe === 1'b1) return PORT_READ;
        return PORT_NOACC;
    endfunction

endpackage

// File: rtl/reg_file_port.sv
// One register-file port: tri-state read driver plus X-safe write request.
module reg_file_port
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] rd_val,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    port_op_e op;

    assign op      = port_decode(cs, we, oe);
    assign wr_en   = (op == PORT_WRITE);
    assign wr_addr = addr;
    assign wr_data = data;

    assign data = (op == PORT_READ) ? rd_val : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/reg_file.sv
// Dual-port 32x8 general-purpose register file; combinational reads, edge writes.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH   = RF_DATA_WIDTH,
    parameter int R_ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int REG_COUNT    = RF_REG_COUNT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [R_ADDR_WIDTH-1:0] rd_addr,
    inout  wire  [DATA_WIDTH-1:0]   rd_data,
    input  logic                    rd_cs,
    input  logic                    rd_we,
    input  logic                    rd_oe,
    input  logic [R_ADDR_WIDTH-1:0] rr_addr,
    inout  wire  [DATA_WIDTH-1:0]   rr_data,
    input  logic                    rr_cs,
    input  logic                    rr_we,
    input  logic                    rr_oe
);

    logic [DATA_WIDTH-1:0]   regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0]   regs_d [REG_COUNT];

    logic                    rd_wr_en,   rr_wr_en;
    logic [R_ADDR_WIDTH-1:0] rd_wr_addr, rr_wr_addr;
    logic [DATA_WIDTH-1:0]   rd_wr_data, rr_wr_data;

    reg_file_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(R_ADDR_WIDTH)) u_rd_port (
        .cs      (rd_cs),
        .we      (rd_we),
        .oe      (rd_oe),
        .addr    (rd_addr),
        .rd_val  (regs_q[rd_addr]),
        .data    (rd_data),
        .wr_en   (rd_wr_en),
        .wr_addr (rd_wr_addr),
        .wr_data (rd_wr_data)
    );

    reg_file_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(R_ADDR_WIDTH)) u_rr_port (
        .cs      (rr_cs),
        .we      (rr_we),
        .oe      (rr_oe),
        .addr    (rr_addr),
        .rd_val  (regs_q[rr_addr]),
        .data    (rr_data),
        .wr_en   (rr_wr_en),
        .wr_addr (rr_wr_addr),
        .wr_data (rr_wr_data)
    );

    // Rd is applied last so it overrides Rr on a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (rr_wr_en) regs_d[rr_wr_addr] = rr_wr_data;
        if (rd_wr_en) regs_d[rd_wr_addr] = rd_wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboarded random/directed bench for the dual-port register file.
module tb_reg_file;

    typedef struct {
        logic [7:0] val;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       p_cs [2];
    logic       p_we [2];
    logic       p_oe [2];
    logic [4:0] p_addr [2];
    logic [7:0] p_wd [2];
    logic       p_drv_en [2];
    logic [7:0] p_drv [2];
    logic       chk [2];

    wire  [7:0] rd_data;
    wire  [7:0] rr_data;

    logic [7:0] model [32];
    exp_t       q0[$];
    exp_t       q1[$];
    exp_t       e0, e1;
    string      tag = "init";
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    assign rd_data = p_drv_en[0] ? p_drv[0] : 8'hzz;
    assign rr_data = p_drv_en[1] ? p_drv[1] : 8'hzz;

    reg_file #(.DATA_WIDTH(8), .R_ADDR_WIDTH(5), .REG_COUNT(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (p_addr[0]),
        .rd_data (rd_data),
        .rd_cs   (p_cs[0]),
        .rd_we   (p_we[0]),
        .rd_oe   (p_oe[0]),
        .rr_addr (p_addr[1]),
        .rr_data (rr_data),
        .rr_cs   (p_cs[1]),
        .rr_we   (p_we[1]),
        .rr_oe   (p_oe[1])
    );

    task automatic compare(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    // Monitor: whenever a port is under observation, pop its expectation.
    always @(negedge clk) begin
        if (chk[0]) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_queue: got empty expected entry");
            end else begin
                e0 = q0.pop_front();
                compare(e0.name, rd_data, e0.val);
            end
        end
        if (chk[1]) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL rr_queue: got empty expected entry");
            end else begin
                e1 = q1.pop_front();
                compare(e1.name, rr_data, e1.val);
            end
        end
    end

    task automatic setp(input int p, input logic cs, input logic we, input logic oe,
                        input logic [4:0] a, input logic [7:0] d);
        p_cs[p] = cs; p_we[p] = we; p_oe[p] = oe; p_addr[p] = a; p_wd[p] = d;
    endtask

    task automatic idle_all();
        setp(0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        setp(1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    endtask

    // One bus cycle: post expectations from the pre-edge model, then commit writes.
    task automatic step();
        logic is_rd [2];
        logic is_wr [2];
        exp_t ex;
        for (int p = 0; p < 2; p++) begin
            is_wr[p] = (p_cs[p] === 1'b1) && (p_we[p] === 1'b1);
            is_rd[p] = (p_cs[p] === 1'b1) && (p_we[p] !== 1'b1) && (p_oe[p] === 1'b1);
            p_drv_en[p] = !is_rd[p];
            p_drv[p] = is_wr[p] ? p_wd[p] : 8'h00;
            if (!is_wr[p]) begin
                ex.val = is_rd[p] ? model[p_addr[p]] : 8'h00;
                ex.name = $sformatf("%s %s %s r%0d", tag, (p == 0) ? "rd" : "rr",
                                    is_rd[p] ? "read" : "hiz", is_rd[p] ? p_addr[p] : 5'd0);
                if (p == 0) q0.push_back(ex); else q1.push_back(ex);
            end
            chk[p] = !is_wr[p];
        end
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 8'h00;
        end else if (is_wr[0] && is_wr[1] && p_addr[0] == p_addr[1]) begin
            model[p_addr[0]] = p_wd[0];
        end else begin
            if (is_wr[0]) model[p_addr[0]] = p_wd[0];
            if (is_wr[1]) model[p_addr[1]] = p_wd[1];
        end
        #1;
        chk[0] = 1'b0;
        chk[1] = 1'b0;
    endtask

    initial begin
        chk[0] = 1'b0; chk[1] = 1'b0;
        p_drv_en[0] = 1'b0; p_drv_en[1] = 1'b0;
        p_drv[0] = 8'h00; p_drv[1] = 8'h00;
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        idle_all();
        @(posedge clk); #1;

        tag = "rst0"; reset = 1'b1; step();
        reset = 1'b0;
        tag = "after_rst";
        setp(0, 1, 0, 1, 5'd0, 8'h00); setp(1, 1, 0, 1, 5'd31, 8'h00); step();

        tag = "preload";
        for (int i = 0; i < 16; i++) begin
            setp(0, 1, 1, 0, 5'(2 * i), 8'hFF); setp(1, 1, 1, 0, 5'(2 * i + 1), 8'hFF); step();
        end
        tag = "read_in_rst";
        reset = 1'b1;
        setp(0, 1, 0, 1, 5'd31, 8'h00); setp(1, 1, 0, 1, 5'd15, 8'h00); step();
        reset = 1'b0;
        tag = "cleared";
        for (int a = 0; a < 32; a += 15) begin
            setp(0, 1, 0, 1, 5'(a), 8'h00); setp(1, 1, 0, 1, 5'(a), 8'h00); step();
        end

        tag = "rdw";
        setp(0, 1, 1, 0, 5'd3, 8'h5A); setp(1, 1, 0, 1, 5'd3, 8'h00); step();
        setp(0, 1, 0, 1, 5'd3, 8'h00); setp(1, 1, 0, 1, 5'd3, 8'h00); step();

        tag = "wb16";
        setp(0, 1, 1, 1, 5'd0, 8'h34); setp(1, 1, 1, 1, 5'd1, 8'h12); step();
        setp(0, 1, 0, 1, 5'd0, 8'h00); setp(1, 1, 0, 1, 5'd1, 8'h00); step();

        tag = "collide";
        setp(0, 1, 1, 0, 5'd26, 8'hAA); setp(1, 1, 1, 0, 5'd26, 8'h55); step();
        setp(0, 1, 0, 1, 5'd26, 8'h00); setp(1, 1, 0, 1, 5'd26, 8'h00); step();

        tag = "cs0_x";
        setp(0, 1'b0, 1'bx, 1'bx, 5'bx, 8'hxx); setp(1, 1'b0, 1'bx, 1'bx, 5'bx, 8'hxx); step();
        tag = "noacc";
        setp(0, 1, 0, 0, 5'd26, 8'h00); setp(1, 1, 0, 0, 5'd3, 8'h00); step();
        tag = "kept";
        setp(0, 1, 0, 1, 5'd3, 8'h00); setp(1, 1, 0, 1, 5'd26, 8'h00); step();
        setp(0, 1, 0, 1, 5'd0, 8'h00); setp(1, 1, 0, 1, 5'd1, 8'h00); step();

        tag = "rst_wr";
        reset = 1'b1;
        setp(0, 1, 1, 0, 5'd5, 8'h77); setp(1, 0, 0, 0, 5'd0, 8'h00); step();
        reset = 1'b0;
        setp(0, 1, 0, 1, 5'd5, 8'h00); setp(1, 1, 0, 1, 5'd26, 8'h00); step();
        setp(0, 1, 1, 0, 5'd5, 8'h77); setp(1, 1, 0, 1, 5'd5, 8'h00); step();
        setp(0, 1, 0, 1, 5'd5, 8'h00); setp(1, 1, 0, 1, 5'd5, 8'h00); step();

        tag = "rand";
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            for (int p = 0; p < 2; p++) begin
                setp(p, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3) != 0,
                     ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31)),
                     8'($urandom));
            end
            step();
        end
        reset = 1'b0;
        idle_all();
        @(negedge clk);

        if (q0.size() != 0 || q1.size() != 0) begin
            checks++; errors++;
            $display("FAIL leftover: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
